// File: rtl/asic_por_seq.sv
// asic_por_seq -- core-side power-on sequencer for the IO ring.
//
// Synchronizes and qualifies the ring's asynchronous `poc` net. Once the IO
// supply is valid it first grants pad output enables, then releases core
// reset. Any captured `poc` reassertion collapses everything back to the safe
// state.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth for poc (>=2)
//   STABLE_CYCLES cycles synchronized poc must stay low before io_en (>=1)
//   IO_TO_CORE    cycles from io_en rising to core_rst falling (>=1)
//
// Ports:
//   clk        in   sequencer clock
//   rst        in   asynchronous active-high reset
//   poc        in   1 = IO supply invalid (asynchronous)
//   hold       in   synchronous hold; blocks OFF->STABLE and IO_ON->RUN
//   io_en      out  pad output-enable permission
//   core_rst   out  active-high core reset
//   ready      out  sequence complete (~core_rst)
//   glitch_cnt out  saturating count of poc reassertions while in RUN
//
// Build option: define ASIC_POR_GLITCH_CNT_EN to implement glitch_cnt;
// otherwise it is tied to zero and no counter flops exist.

module asic_por_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned IO_TO_CORE    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poc,
  input  logic       hold,
  output logic       io_en,
  output logic       core_rst,
  output logic       ready,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned MAX_CNT = (STABLE_CYCLES > IO_TO_CORE) ? STABLE_CYCLES : IO_TO_CORE;
  localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] IO_LAST     = CW'(IO_TO_CORE - 1);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    STABLE = 2'd1,
    IO_ON  = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   poc_s;
  logic                   io_en_d, core_rst_d;

  // Synchronizer resets to all-ones so poc reads as asserted out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], poc};
  end

  assign poc_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      cnt      <= '0;
      io_en    <= 1'b0;
      core_rst <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      io_en    <= io_en_d;
      core_rst <= core_rst_d;
      ready    <= ~core_rst_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (poc_s) begin
      state_d = OFF;
    end else begin
      unique case (state)
        OFF: begin
          if (!hold) state_d = STABLE;
        end
        STABLE: begin
          if (cnt == STABLE_LAST) state_d = IO_ON;
          else                    cnt_d   = cnt + 1'b1;
        end
        IO_ON: begin
          if (cnt >= IO_LAST && !hold) state_d = RUN;
          else if (cnt < IO_LAST)      cnt_d   = cnt + 1'b1;
        end
        RUN: ;
        default: state_d = OFF;
      endcase
    end
    // Counter restarts on every state change.
    if (state_d != state) cnt_d = '0;
    // Outputs are registered from the next-state decode so they move with the state.
    io_en_d    = (state_d == IO_ON) || (state_d == RUN);
    core_rst_d = (state_d != RUN);
  end

`ifdef ASIC_POR_GLITCH_CNT_EN
  logic       glitch_inc;
  logic [7:0] glitch_q;

  assign glitch_inc = poc_s && (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             glitch_q <= '0;
    else if (glitch_inc && glitch_q != '1) glitch_q <= glitch_q + 8'd1;
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule
